// File: rtl/sw_ctrl_pkg.sv
// Shared encodings and constants for the stopwatch button front end.
package sw_ctrl_pkg;

  localparam int DBNC_CNT_W = 8;

  localparam logic MODE_CLOCK = 1'b0;
  localparam logic MODE_STOP  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } run_state_e;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: synchroniser, hold-time debounce and a press strobe that is
// only armed once the button has been seen released after reset.
module btn_debounce
  import sw_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [DBNC_CNT_W-1:0] CNT_LAST = DBNC_CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [DBNC_CNT_W-1:0] CNT_ONE  = DBNC_CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic [DBNC_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   armed_q, armed_d;
  logic                   press_q, press_d;
  logic                   sync_in, differ, expired;

  assign sync_in = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: each variable driven here gets a default first, so no latch can be inferred.
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn_i};
    vld_d   = {vld_q[SYNC_STAGES-2:0], 1'b1};
    differ  = sync_in ^ level_q;
    expired = differ && (cnt_q == CNT_LAST);
    cnt_d   = '0;
    level_d = level_q;
    if (expired) begin
      level_d = sync_in;
    end else if (differ) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // The sync chain reads 0 straight out of reset, so its output is trusted
    // only once the valid shifter has filled.
    armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~sync_in);
    press_d = expired & sync_in & armed_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      vld_q   <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sw_button_ctrl.sv
// Stopwatch control front end: three debounced buttons drive a display-mode
// flop and an IDLE/RUNNING/PAUSED machine issuing one-cycle command pulses.
module sw_button_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock_1MSec,
  input  logic Reset,
  input  logic Btn_Mode,
  input  logic Btn_StartStop,
  input  logic Btn_Reset,
  output logic Control,
  output logic Start_S,
  output logic Stop_S,
  output logic Reset_S,
  output logic Run_S
);

  logic       mode_ev, ss_ev, clr_ev;
  run_state_e state_q, state_d;
  logic       control_q, control_d;
  logic       start_q, start_d, stop_q, stop_d, clr_q, clr_d, run_q, run_d;
  logic       stop_mode;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_dbnc_mode (
    .clk(Clock_1MSec), .rst_n(Reset), .btn_i(Btn_Mode), .press_o(mode_ev)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_dbnc_ss (
    .clk(Clock_1MSec), .rst_n(Reset), .btn_i(Btn_StartStop), .press_o(ss_ev)
  );
  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_dbnc_clr (
    .clk(Clock_1MSec), .rst_n(Reset), .btn_i(Btn_Reset), .press_o(clr_ev)
  );

  // Command decisions use the pre-toggle mode, so a simultaneous Mode press
  // does not change how StartStop/Reset are treated this cycle.
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    stop_d    = 1'b0;
    clr_d     = 1'b0;
    stop_mode = (control_q == MODE_STOP);
    control_d = control_q ^ mode_ev;
    case (state_q)
      IDLE: begin
        if (stop_mode && clr_ev) begin
          clr_d = 1'b1;
        end else if (stop_mode && ss_ev) begin
          state_d = RUNNING;
          start_d = 1'b1;
        end
      end
      RUNNING: begin
        if (stop_mode && ss_ev) begin
          state_d = PAUSED;
          stop_d  = 1'b1;
        end
      end
      PAUSED: begin
        if (stop_mode && clr_ev) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else if (stop_mode && ss_ev) begin
          state_d = RUNNING;
          start_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d == RUNNING);
  end

  always_ff @(posedge Clock_1MSec or negedge Reset) begin
    if (!Reset) begin
      state_q   <= IDLE;
      control_q <= MODE_CLOCK;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clr_q     <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      control_q <= control_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      clr_q     <= clr_d;
      run_q     <= run_d;
    end
  end

  assign Control = control_q;
  assign Start_S = start_q;
  assign Stop_S  = stop_q;
  assign Reset_S = clr_q;
  assign Run_S   = run_q;

endmodule

// File: tb/tb_sw_button_ctrl.sv
// Directed and random stimulus for sw_button_ctrl, checked every cycle against
// a history-based behavioural model of debounce, arming and run control.
module tb_sw_button_ctrl;

  localparam int D = 4;
  localparam int S = 2;
  localparam int HMAX = 16384;

  typedef enum {M_IDLE, M_RUN, M_PAUSE} m_state_e;

  logic clk = 1'b0;
  logic rst_n, b_mode, b_ss, b_rst;
  logic Control, Start_S, Stop_S, Reset_S, Run_S;

  int tests = 0;
  int fails = 0;
  int n_start = 0, n_stop = 0, n_clr = 0;

  // model state
  int       edge_n;
  bit       hist [3][HMAX];
  bit       syn  [3][HMAX];
  bit       lvl [3], armed [3], ev [3];
  bit       m_ctrl, m_start, m_stop, m_clr;
  m_state_e m_st;

  sw_button_ctrl #(.DEBOUNCE_MS(D), .SYNC_STAGES(S)) dut (
    .Clock_1MSec  (clk),
    .Reset        (rst_n),
    .Btn_Mode     (b_mode),
    .Btn_StartStop(b_ss),
    .Btn_Reset    (b_rst),
    .Control      (Control),
    .Start_S      (Start_S),
    .Stop_S       (Stop_S),
    .Reset_S      (Reset_S),
    .Run_S        (Run_S)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_n = 0;
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 0; armed[b] = 0; ev[b] = 0;
    end
    m_ctrl = 0; m_start = 0; m_stop = 0; m_clr = 0;
    m_st = M_IDLE;
  endtask

  // One rising edge of the reference: commands act on presses recognised at
  // the previous edge; a press is a debounced rise once the button was seen released.
  task automatic model_step();
    bit raw [3];
    bit sy, flip;
    raw[0] = b_mode; raw[1] = b_ss; raw[2] = b_rst;
    edge_n++;
    m_start = 0; m_stop = 0; m_clr = 0;
    if (m_ctrl) begin
      if (m_st == M_RUN) begin
        if (ev[1]) begin m_stop = 1; m_st = M_PAUSE; end
      end else if (ev[2]) begin
        m_clr = 1; m_st = M_IDLE;
      end else if (ev[1]) begin
        m_start = 1; m_st = M_RUN;
      end
    end
    if (ev[0]) m_ctrl = !m_ctrl;
    for (int b = 0; b < 3; b++) begin
      hist[b][edge_n-1] = raw[b];
      sy = (edge_n > S) ? hist[b][edge_n-1-S] : 1'b0;
      syn[b][edge_n-1] = sy;
      flip = (edge_n >= D);
      for (int k = 0; k < D; k++)
        if (flip && syn[b][edge_n-1-k] == lvl[b]) flip = 0;
      ev[b] = flip && !lvl[b] && armed[b];
      if (flip) lvl[b] = !lvl[b];
      if (edge_n > S && !sy) armed[b] = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    check("Control", Control, m_ctrl);
    check("Start_S", Start_S, m_start);
    check("Stop_S",  Stop_S,  m_stop);
    check("Reset_S", Reset_S, m_clr);
    check("Run_S",   Run_S,   (m_st == M_RUN));
    if (Start_S === 1'b1) n_start++;
    if (Stop_S  === 1'b1) n_stop++;
    if (Reset_S === 1'b1) n_clr++;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       b_mode = v;
      1:       b_ss   = v;
      default: b_rst  = v;
    endcase
  endtask

  task automatic press(input int b, input int hold);
    set_btn(b, 1'b1);
    repeat (hold) tick();
    set_btn(b, 1'b0);
    repeat (10) tick();
  endtask

  initial begin
    int lat, s0, p0, c0, st0;
    int left [3];
    rst_n = 1'b0; b_mode = 1'b1; b_ss = 1'b1; b_rst = 1'b0;
    model_reset();
    repeat (10) tick();
    check("rst_Control", Control, 1'b0);
    check("rst_Run_S", Run_S, 1'b0);

    // Buttons held across reset release must not act.
    rst_n = 1'b1;
    repeat (20) tick();
    check("held_no_toggle", Control, 1'b0);
    check("held_no_start", n_start, 0);
    b_mode = 1'b0; b_ss = 1'b0;
    repeat (10) tick();

    b_mode = 1'b1; lat = 0;
    do begin tick(); lat++; end while (Control !== 1'b1 && lat < 20);
    check("mode_latency", lat, 7);
    b_mode = 1'b0;
    repeat (10) tick();

    b_ss = 1'b1; lat = 0;
    do begin tick(); lat++; end while (Start_S !== 1'b1 && lat < 20);
    check("start_latency", lat, 7);
    check("run_with_start", Run_S, 1'b1);
    tick();
    check("start_one_cycle", Start_S, 1'b0);
    b_ss = 1'b0;
    repeat (10) tick();

    // Pause, then a bouncy press yields a single Start_S.
    press(1, 8);
    s0 = n_start;
    for (int i = 0; i < 4; i++) begin
      b_ss = (i % 2 == 0); repeat (2) tick();
    end
    b_ss = 1'b1; repeat (10) tick();
    b_ss = 1'b0; repeat (10) tick();
    check("bounce_one_start", n_start - s0, 1);
    check("bounce_running", Run_S, 1'b1);

    p0 = n_stop;
    b_ss = 1'b1; repeat (3) tick(); b_ss = 1'b0;
    repeat (10) tick();
    check("glitch_no_stop", n_stop - p0, 0);

    c0 = n_clr;
    press(2, 8);
    check("run_reset_ignored", n_clr - c0, 0);
    check("run_reset_still_run", Run_S, 1'b1);
    press(1, 8);
    check("stop_pulse", n_stop - p0, 1);
    check("stop_run_low", Run_S, 1'b0);
    press(2, 8);
    check("paused_clear", n_clr - c0, 1);

    // Simultaneous StartStop + Reset from PAUSED, then from RUNNING.
    press(1, 8); press(1, 8);
    c0 = n_clr; st0 = n_start;
    b_ss = 1'b1; b_rst = 1'b1; repeat (8) tick();
    b_ss = 1'b0; b_rst = 1'b0; repeat (10) tick();
    check("both_paused_clr", n_clr - c0, 1);
    check("both_paused_nostart", n_start - st0, 0);
    press(1, 8);
    c0 = n_clr; p0 = n_stop;
    b_ss = 1'b1; b_rst = 1'b1; repeat (8) tick();
    b_ss = 1'b0; b_rst = 1'b0; repeat (10) tick();
    check("both_run_stop", n_stop - p0, 1);
    check("both_run_noclr", n_clr - c0, 0);

    // Time-of-day mode discards StartStop and Reset.
    press(0, 8);
    check("clock_mode", Control, 1'b0);
    st0 = n_start; c0 = n_clr;
    press(1, 8); press(2, 8);
    check("clock_no_start", n_start - st0, 0);
    check("clock_no_clr", n_clr - c0, 0);
    check("clock_state_kept", Run_S, 1'b0);
    press(0, 8);
    press(1, 8);
    check("resume_start", n_start - st0, 1);

    // Reset in the middle of a debounce with the button still held.
    b_mode = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0; model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("abort_no_toggle", Control, 1'b0);
    b_mode = 1'b0;
    repeat (10) tick();
    press(0, 8);
    check("rearm_toggle", Control, 1'b1);

    // Random button activity, with one reset in the middle.
    for (int b = 0; b < 3; b++) left[b] = 0;
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin rst_n = 1'b0; model_reset(); end
      if (i == 303) rst_n = 1'b1;
      for (int b = 0; b < 3; b++) begin
        if (left[b] == 0) begin
          case (b)
            0:       b_mode = ~b_mode;
            1:       b_ss   = ~b_ss;
            default: b_rst  = ~b_rst;
          endcase
          left[b] = $urandom_range(1, 12);
        end else begin
          left[b]--;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
